// File: rtl/exec_muldiv_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_muldiv_if : decode-side handshake and result bus of exec_muldiv |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface exec_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic             check_overflow;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] const_val;
  logic [7:0]       exception_in;
  logic             out_valid;
  logic [WIDTH-1:0] out_val;
  logic [7:0]       exception;
  logic             busy;

  modport master (
    output in_valid, op, check_overflow, rs_val, rt_val, const_val, exception_in,
    input  in_ready, out_valid, out_val, exception, busy
  );

  modport slave (
    input  in_valid, op, check_overflow, rs_val, rt_val, const_val, exception_in,
    output in_ready, out_valid, out_val, exception, busy
  );
endinterface
`default_nettype wire

// File: rtl/exec_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_muldiv : execute-stage ALU with HI/LO and iterative mul/div.   |
// | EXEC_MULDIV_FAST_MUL_EN selects a single-cycle multiplier. rev 1.0  |
// +--------------------------------------------------------------------+
package exec_muldiv_pkg;
  localparam logic [5:0] ALU_ADD     = 6'd0;
  localparam logic [5:0] ALU_SUB     = 6'd1;
  localparam logic [5:0] ALU_AND     = 6'd2;
  localparam logic [5:0] ALU_OR      = 6'd3;
  localparam logic [5:0] ALU_XOR     = 6'd4;
  localparam logic [5:0] ALU_NOR     = 6'd5;
  localparam logic [5:0] ALU_SLT     = 6'd6;
  localparam logic [5:0] ALU_SLTU    = 6'd7;
  localparam logic [5:0] ALU_SLL     = 6'd8;
  localparam logic [5:0] ALU_SRL     = 6'd9;
  localparam logic [5:0] ALU_SRA     = 6'd10;
  localparam logic [5:0] ALU_LUI     = 6'd11;
  localparam logic [5:0] ALU_MACCESS = 6'd12;
  localparam logic [5:0] ALU_MULT    = 6'd13;
  localparam logic [5:0] ALU_MULTU   = 6'd14;
  localparam logic [5:0] ALU_DIV     = 6'd15;
  localparam logic [5:0] ALU_DIVU    = 6'd16;
  localparam logic [5:0] ALU_MFHI    = 6'd17;
  localparam logic [5:0] ALU_MFLO    = 6'd18;
  localparam logic [5:0] ALU_MTHI    = 6'd19;
  localparam logic [5:0] ALU_MTLO    = 6'd20;

  localparam logic [7:0] TRAP_STALL    = 8'h01;
  localparam logic [7:0] TRAP_OVERFLOW = 8'h0C;
endpackage

module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  exec_muldiv_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_q, wrk_q, opnd_q, rs_q;
  logic             is_div_q, neg_q, neg_rem_q, dz_q;
  logic             busy_q, out_valid_q;
  logic [WIDTH-1:0] out_val_q;
  logic [7:0]       exc_q;

  logic             accept, is_iter, is_div, is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag, rt_twos;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge, last_iter;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] alu_val_d;
  logic [7:0]       alu_exc_d;
`ifdef EXEC_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`else
  logic [WIDTH:0]   mul_sum;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    rt_twos   = ~bus.rt_val + WIDTH'(1);
    add_sum   = {bus.rs_val[WIDTH-1], bus.rs_val} + {bus.rt_val[WIDTH-1], bus.rt_val};
    sub_sum   = {bus.rs_val[WIDTH-1], bus.rs_val} + {rt_twos[WIDTH-1], rt_twos};
    alu_val_d = '0;
    alu_exc_d = 8'h00;
    case (bus.op)
      ALU_ADD:
        if (bus.check_overflow && (add_sum[WIDTH] ^ add_sum[WIDTH-1])) alu_exc_d = TRAP_OVERFLOW;
        else alu_val_d = add_sum[WIDTH-1:0];
      ALU_SUB:
        if (bus.check_overflow && (sub_sum[WIDTH] ^ sub_sum[WIDTH-1])) alu_exc_d = TRAP_OVERFLOW;
        else alu_val_d = sub_sum[WIDTH-1:0];
      ALU_AND:     alu_val_d = bus.rs_val & bus.rt_val;
      ALU_OR:      alu_val_d = bus.rs_val | bus.rt_val;
      ALU_XOR:     alu_val_d = bus.rs_val ^ bus.rt_val;
      ALU_NOR:     alu_val_d = ~(bus.rs_val | bus.rt_val);
      ALU_SLT:     alu_val_d = {{(WIDTH-1){1'b0}}, $signed(bus.rs_val) < $signed(bus.rt_val)};
      ALU_SLTU:    alu_val_d = {{(WIDTH-1){1'b0}}, bus.rs_val < bus.rt_val};
      ALU_SLL:     alu_val_d = bus.rt_val << bus.rs_val[SH_W-1:0];
      ALU_SRL:     alu_val_d = bus.rt_val >> bus.rs_val[SH_W-1:0];
      ALU_SRA:     alu_val_d = $signed(bus.rt_val) >>> bus.rs_val[SH_W-1:0];
      ALU_LUI:     alu_val_d = bus.const_val << (WIDTH / 2);
      ALU_MACCESS: alu_val_d = bus.rs_val + bus.const_val;
      ALU_MFHI:    alu_val_d = hi_q;
      ALU_MFLO:    alu_val_d = lo_q;
      ALU_MTHI, ALU_MTLO, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: alu_val_d = '0;
      default:     alu_exc_d = TRAP_STALL;
    endcase
    if (bus.exception_in != 8'h00) begin
      alu_val_d = '0;
      alu_exc_d = bus.exception_in;
    end
  end

  // Signed ops iterate on magnitudes; signs are reapplied when HI/LO are written.
  always_comb begin
    is_div    = (bus.op == ALU_DIV) || (bus.op == ALU_DIVU);
    is_iter   = is_div || (bus.op == ALU_MULT) || (bus.op == ALU_MULTU);
    is_signed = (bus.op == ALU_MULT) || (bus.op == ALU_DIV);
    rs_neg    = is_signed && bus.rs_val[WIDTH-1];
    rt_neg    = is_signed && bus.rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
    div_shift = {acc_q, wrk_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    prod_fix  = neg_q ? -{acc_q, wrk_q} : {acc_q, wrk_q};
`ifdef EXEC_MULDIV_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, wrk_q};
`else
    mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      wrk_q       <= '0;
      opnd_q      <= '0;
      rs_q        <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      exc_q       <= TRAP_STALL;
    end else begin
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      exc_q       <= 8'h00;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_iter && (bus.exception_in == 8'h00)) begin
              state_q   <= is_div ? S_DIV : S_MUL;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              acc_q     <= '0;
              opnd_q    <= is_div ? rt_mag : rs_mag;
              wrk_q     <= is_div ? rs_mag : rt_mag;
              rs_q      <= bus.rs_val;
              is_div_q  <= is_div;
              neg_q     <= rs_neg ^ rt_neg;
              neg_rem_q <= rs_neg;
              dz_q      <= (bus.rt_val == '0);
            end else begin
              out_valid_q <= 1'b1;
              out_val_q   <= alu_val_d;
              exc_q       <= alu_exc_d;
              if (bus.exception_in == 8'h00 && bus.op == ALU_MTHI) hi_q <= bus.rs_val;
              if (bus.exception_in == 8'h00 && bus.op == ALU_MTLO) lo_q <= bus.rs_val;
            end
          end
        end
        S_MUL: begin
`ifdef EXEC_MULDIV_FAST_MUL_EN
          {acc_q, wrk_q} <= fast_prod;
          state_q        <= S_DONE;
          out_valid_q    <= 1'b1;
`else
          acc_q <= mul_sum[WIDTH:1];
          wrk_q <= {mul_sum[0], wrk_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
`endif
        end
        S_DIV: begin
          acc_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          wrk_q <= {wrk_q[WIDTH-2:0], div_ge};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (dz_q) begin
            lo_q <= '1;
            hi_q <= rs_q;
          end else begin
            lo_q <= neg_q ? -wrk_q : wrk_q;
            hi_q <= neg_rem_q ? -acc_q : acc_q;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !busy_q && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_val   = out_val_q;
  assign bus.exception = exc_q;
  assign bus.busy      = busy_q;
endmodule
`default_nettype wire
